// File: rtl/idli_uart_trx_m.sv
// Full-duplex buffered UART: start bit, DATA_W data bits LSB first, stop bit.
// Per-direction FIFOs with valid/accept handshakes and sticky RX framing/overflow flags.
module idli_uart_trx_m #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CLK_DIV  = 16,
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic              i_uart_gck,
  input  logic              i_uart_rst_n,
  input  logic [DATA_W-1:0] i_uart_tx_data,
  input  logic              i_uart_tx_vld,
  output logic              o_uart_tx_acp,
  output logic [DATA_W-1:0] o_uart_rx_data,
  output logic              o_uart_rx_vld,
  input  logic              i_uart_rx_acp,
  input  logic              i_uart_err_clr,
  output logic              o_uart_tx_busy,
  output logic              o_uart_rx_ferr,
  output logic              o_uart_rx_ovf,
  input  logic              i_uart_rx,
  output logic              o_uart_tx
);
  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned IDX_W = $clog2(DATA_W + 1);
  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned TX_PW = TX_AW + 1;
  localparam int unsigned RX_PW = RX_AW + 1;
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  if (CLK_DIV < 4 || (CLK_DIV % 2) != 0) begin : g_chk_div
    $error("idli_uart_trx_m: CLK_DIV must be even and >= 4");
  end
  if (DATA_W < 5 || DATA_W > 9) begin : g_chk_dw
    $error("idli_uart_trx_m: DATA_W must be 5..9");
  end
  if (TX_DEPTH < 2 || (TX_DEPTH & (TX_DEPTH - 1)) != 0 ||
      RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("idli_uart_trx_m: FIFO depths must be powers of two >= 2");
  end

  // TX FIFO: pointers carry a wrap bit so full and empty are distinguishable
  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [TX_PW-1:0]  tx_wr, tx_rd, tx_wr_nxt, tx_rd_nxt;
  logic              tx_push, tx_pop, tx_empty;
  logic [DATA_W-1:0] tx_head;

  assign tx_push   = i_uart_tx_vld & o_uart_tx_acp;
  assign tx_empty  = (tx_wr == tx_rd);
  assign tx_head   = tx_mem[tx_rd[TX_AW-1:0]];
  assign tx_wr_nxt = tx_wr + TX_PW'(tx_push);
  assign tx_rd_nxt = tx_rd + TX_PW'(tx_pop);

  always_ff @(posedge i_uart_gck) begin
    if (tx_push) tx_mem[tx_wr[TX_AW-1:0]] <= i_uart_tx_data;
  end

  logic [1:0]        tx_state, tx_state_nxt;
  logic [CNT_W-1:0]  tx_cnt, tx_cnt_nxt;
  logic [IDX_W-1:0]  tx_idx, tx_idx_nxt;
  logic [DATA_W-1:0] tx_sh, tx_sh_nxt;
  logic              tx_bit_c;

  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt + CNT_W'(1);
    tx_idx_nxt   = tx_idx;
    tx_sh_nxt    = tx_sh;
    tx_pop       = 1'b0;
    case (tx_state)
      S_IDLE: begin
        tx_cnt_nxt = '0;
        if (!tx_empty) begin
          tx_pop       = 1'b1;
          tx_sh_nxt    = tx_head;
          tx_state_nxt = S_START;
        end
      end
      S_START: if (tx_cnt == CNT_BIT) begin
        tx_cnt_nxt   = '0;
        tx_idx_nxt   = '0;
        tx_state_nxt = S_DATA;
      end
      S_DATA: if (tx_cnt == CNT_BIT) begin
        tx_cnt_nxt = '0;
        tx_sh_nxt  = tx_sh >> 1;
        if (tx_idx == IDX_LAST) tx_state_nxt = S_STOP;
        else                    tx_idx_nxt   = tx_idx + IDX_W'(1);
      end
      S_STOP: if (tx_cnt == CNT_BIT) begin
        tx_cnt_nxt = '0;
        // back-to-back frames: next start bit follows the stop bit directly
        if (!tx_empty) begin
          tx_pop       = 1'b1;
          tx_sh_nxt    = tx_head;
          tx_state_nxt = S_START;
        end else begin
          tx_state_nxt = S_IDLE;
        end
      end
      default: tx_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx_bit_c = 1'b1;
    case (tx_state)
      S_START: tx_bit_c = 1'b0;
      S_DATA:  tx_bit_c = tx_sh[0];
      default: tx_bit_c = 1'b1;
    endcase
  end

  always_ff @(posedge i_uart_gck or negedge i_uart_rst_n) begin
    if (!i_uart_rst_n) begin
      tx_state       <= S_IDLE;
      tx_cnt         <= '0;
      tx_idx         <= '0;
      tx_sh          <= '0;
      tx_wr          <= '0;
      tx_rd          <= '0;
      o_uart_tx      <= 1'b1;
      o_uart_tx_acp  <= 1'b1;
      o_uart_tx_busy <= 1'b0;
    end else begin
      tx_state       <= tx_state_nxt;
      tx_cnt         <= tx_cnt_nxt;
      tx_idx         <= tx_idx_nxt;
      tx_sh          <= tx_sh_nxt;
      tx_wr          <= tx_wr_nxt;
      tx_rd          <= tx_rd_nxt;
      o_uart_tx      <= tx_bit_c;
      o_uart_tx_acp  <= (tx_wr_nxt - tx_rd_nxt) != TX_PW'(TX_DEPTH);
      o_uart_tx_busy <= (tx_wr_nxt != tx_rd_nxt) || (tx_state_nxt != S_IDLE);
    end
  end

  // RX FIFO; fullness is taken from the current pointers so a same-cycle pop cannot admit a push
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [RX_PW-1:0]  rx_wr, rx_rd, rx_wr_nxt, rx_rd_nxt;
  logic              rx_push, rx_pop, rx_full;
  logic [DATA_W-1:0] rx_head_nxt;
  logic              rx_s1, rx_s2;

  logic [1:0]        rx_state, rx_state_nxt;
  logic [CNT_W-1:0]  rx_cnt, rx_cnt_nxt;
  logic [IDX_W-1:0]  rx_idx, rx_idx_nxt;
  logic [DATA_W-1:0] rx_sh, rx_sh_nxt;
  logic              rx_ferr_set, rx_ovf_set;

  assign rx_pop      = o_uart_rx_vld & i_uart_rx_acp;
  assign rx_full     = (rx_wr - rx_rd) == RX_PW'(RX_DEPTH);
  assign rx_wr_nxt   = rx_wr + RX_PW'(rx_push);
  assign rx_rd_nxt   = rx_rd + RX_PW'(rx_pop);
  assign rx_head_nxt = (rx_push && (rx_rd_nxt[RX_AW-1:0] == rx_wr[RX_AW-1:0])) ?
                       rx_sh : rx_mem[rx_rd_nxt[RX_AW-1:0]];

  always_ff @(posedge i_uart_gck) begin
    if (rx_push) rx_mem[rx_wr[RX_AW-1:0]] <= rx_sh;
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt + CNT_W'(1);
    rx_idx_nxt   = rx_idx;
    rx_sh_nxt    = rx_sh;
    rx_push      = 1'b0;
    rx_ferr_set  = 1'b0;
    rx_ovf_set   = 1'b0;
    case (rx_state)
      S_IDLE: begin
        rx_cnt_nxt = '0;
        if (!rx_s2) rx_state_nxt = S_START;
      end
      S_START: if (rx_cnt == CNT_HALF) begin
        rx_cnt_nxt   = '0;
        rx_idx_nxt   = '0;
        rx_state_nxt = rx_s2 ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_cnt == CNT_BIT) begin
        rx_cnt_nxt = '0;
        rx_sh_nxt  = {rx_s2, rx_sh[DATA_W-1:1]};
        if (rx_idx == IDX_LAST) rx_state_nxt = S_STOP;
        else                    rx_idx_nxt   = rx_idx + IDX_W'(1);
      end
      S_STOP: if (rx_cnt == CNT_BIT) begin
        rx_cnt_nxt   = '0;
        rx_state_nxt = S_IDLE;
        if (!rx_s2)       rx_ferr_set = 1'b1;
        else if (rx_full) rx_ovf_set  = 1'b1;
        else              rx_push     = 1'b1;
      end
      default: rx_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_uart_gck or negedge i_uart_rst_n) begin
    if (!i_uart_rst_n) begin
      rx_s1          <= 1'b1;
      rx_s2          <= 1'b1;
      rx_state       <= S_IDLE;
      rx_cnt         <= '0;
      rx_idx         <= '0;
      rx_sh          <= '0;
      rx_wr          <= '0;
      rx_rd          <= '0;
      o_uart_rx_data <= '0;
      o_uart_rx_vld  <= 1'b0;
      o_uart_rx_ferr <= 1'b0;
      o_uart_rx_ovf  <= 1'b0;
    end else begin
      rx_s1          <= i_uart_rx;
      rx_s2          <= rx_s1;
      rx_state       <= rx_state_nxt;
      rx_cnt         <= rx_cnt_nxt;
      rx_idx         <= rx_idx_nxt;
      rx_sh          <= rx_sh_nxt;
      rx_wr          <= rx_wr_nxt;
      rx_rd          <= rx_rd_nxt;
      o_uart_rx_data <= rx_head_nxt;
      o_uart_rx_vld  <= (rx_wr_nxt != rx_rd_nxt);
      o_uart_rx_ferr <= rx_ferr_set | (o_uart_rx_ferr & ~i_uart_err_clr);
      o_uart_rx_ovf  <= rx_ovf_set  | (o_uart_rx_ovf  & ~i_uart_err_clr);
    end
  end
endmodule

// File: tb/tb_idli_uart_trx_m.sv
// Directed/randomized bench for idli_uart_trx_m: serial frames are predicted from the
// frame format and byte queues, not from the design's state machine.
module tb_idli_uart_trx_m;
  localparam int unsigned DW = 8;
  localparam int unsigned CD = 4;
  localparam int unsigned FL = (DW + 2) * CD;

  logic          clk = 1'b0;
  logic          rst_n, tx_vld, rx_acp, err_clr, rx_drv, lb;
  logic [DW-1:0] tx_data, rx_data, b;
  logic          tx_acp, rx_vld, tx_busy, ferr, ovf, tx_line, rx_line;
  logic          ok, hi;
  int            w;
  int            n_chk = 0, n_pass = 0, n_fail = 0;
  logic [DW-1:0] exp_q [$];

  always #5 clk = ~clk;
  assign rx_line = lb ? tx_line : rx_drv;

  idli_uart_trx_m #(.DATA_W(DW), .CLK_DIV(CD), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .i_uart_gck     (clk),
    .i_uart_rst_n   (rst_n),
    .i_uart_tx_data (tx_data),
    .i_uart_tx_vld  (tx_vld),
    .o_uart_tx_acp  (tx_acp),
    .o_uart_rx_data (rx_data),
    .o_uart_rx_vld  (rx_vld),
    .i_uart_rx_acp  (rx_acp),
    .i_uart_err_clr (err_clr),
    .o_uart_tx_busy (tx_busy),
    .o_uart_rx_ferr (ferr),
    .o_uart_rx_ovf  (ovf),
    .i_uart_rx      (rx_line),
    .o_uart_tx      (tx_line)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // line level of bit k of a frame: start 0, data LSB first, stop 1
  function automatic logic frame_bit(input logic [DW-1:0] d, input int unsigned k);
    if (k == 0) return 1'b0;
    if (k > DW) return 1'b1;
    return d[k-1];
  endfunction

  task automatic push_byte(input logic [DW-1:0] d, output logic first_ok);
    logic acc;
    acc      = 1'b0;
    tx_data  = d;
    tx_vld   = 1'b1;
    first_ok = tx_acp;
    for (int t = 0; t < 300 && !acc; t++) begin
      acc = tx_acp;
      @(negedge clk);
    end
    tx_vld = 1'b0;
    check("tx_push_accepted", 32'(acc), 32'd1);
  endtask

  task automatic check_tx_stream(input int nbytes, output int waited);
    waited = 0;
    while (tx_line !== 1'b0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("tx_start_found", 32'(tx_line), 32'd0);
    for (int f = 0; f < nbytes; f++)
      for (int k = 0; k < int'(FL); k++) begin
        check("tx_bit", 32'(tx_line), 32'(frame_bit(exp_q[f], k / CD)));
        @(negedge clk);
      end
  endtask

  task automatic send_rx_frame(input logic [DW-1:0] d, input logic stop);
    for (int k = 0; k <= int'(DW) + 1; k++) begin
      rx_drv = (k == int'(DW) + 1) ? stop : frame_bit(d, k);
      repeat (CD) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (CD) @(negedge clk);
  endtask

  task automatic wait_rx_vld(input int lim);
    for (int t = 0; t < lim && rx_vld !== 1'b1; t++) @(negedge clk);
    check("rx_vld_arrived", 32'(rx_vld), 32'd1);
  endtask

  task automatic pop_byte(input logic [DW-1:0] e);
    check("rx_vld_before_pop", 32'(rx_vld), 32'd1);
    check("rx_data", 32'(rx_data), 32'(e));
    rx_acp = 1'b1;
    @(negedge clk);
    rx_acp = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; tx_vld = 1'b0; tx_data = '0; rx_acp = 1'b0;
    err_clr = 1'b0; rx_drv = 1'b1; lb = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_tx", 32'(tx_line), 32'd1);
    check("rst_acp", 32'(tx_acp), 32'd1);
    check("rst_rx_vld", 32'(rx_vld), 32'd0);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_ferr", 32'(ferr), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);

    // single frame: push at E0, line falls at E2, 40 cycles of frame
    exp_q = {8'hA5};
    push_byte(8'hA5, ok);
    check("single_busy", 32'(tx_busy), 32'd1);
    check("single_idle_e0", 32'(tx_line), 32'd1);
    @(negedge clk);
    check("single_idle_e1", 32'(tx_line), 32'd1);
    @(negedge clk);
    check_tx_stream(1, w);
    check("single_latency", 32'(w), 32'd0);
    check("single_busy_done", 32'(tx_busy), 32'd0);

    // burst: 4-deep FIFO plus the byte the FSM takes at once gives 5 before acp drops
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(DW'($urandom));
    fork
      for (int i = 0; i < 6; i++) begin
        push_byte(exp_q[i], ok);
        check("burst_first_try", 32'(ok), 32'(i < 5));
      end
      check_tx_stream(6, w);
    join
    check("burst_busy_done", 32'(tx_busy), 32'd0);
    check("burst_acp_done", 32'(tx_acp), 32'd1);

    // loopback
    lb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b = (i == 0) ? 8'h3C : DW'($urandom);
      push_byte(b, ok);
      wait_rx_vld(200);
      pop_byte(b);
      check("loop_rx_vld_after_pop", 32'(rx_vld), 32'd0);
    end
    repeat (10) @(negedge clk);
    lb = 1'b0;
    repeat (10) @(negedge clk);

    // framing error
    send_rx_frame(8'h55, 1'b0);
    repeat (8) @(negedge clk);
    check("ferr_set", 32'(ferr), 32'd1);
    check("ferr_no_push", 32'(rx_vld), 32'd0);
    check("ferr_no_ovf", 32'(ovf), 32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("ferr_cleared", 32'(ferr), 32'd0);
    repeat (10) @(negedge clk);

    // overflow: fifth frame is dropped, first four survive in order
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      b = DW'($urandom);
      exp_q.push_back(b);
      send_rx_frame(b, 1'b1);
      if (i == 3) begin
        check("ovf_full_vld", 32'(rx_vld), 32'd1);
        check("ovf_not_yet", 32'(ovf), 32'd0);
      end
    end
    repeat (4) @(negedge clk);
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_no_ferr", 32'(ferr), 32'd0);
    for (int i = 0; i < 4; i++) pop_byte(exp_q[i]);
    check("ovf_drained", 32'(rx_vld), 32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("ovf_cleared", 32'(ovf), 32'd0);

    // one-cycle glitch on the line
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_no_push", 32'(rx_vld), 32'd0);
    check("glitch_no_ferr", 32'(ferr), 32'd0);
    check("glitch_no_ovf", 32'(ovf), 32'd0);

    // reset during a start bit with a second byte still queued
    push_byte(DW'($urandom), ok);
    push_byte(DW'($urandom), ok);
    repeat (2) @(negedge clk);
    check("midrst_start_low", 32'(tx_line), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx_high", 32'(tx_line), 32'd1);
    check("midrst_busy", 32'(tx_busy), 32'd0);
    check("midrst_acp", 32'(tx_acp), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    hi = 1'b1;
    repeat (50) begin
      @(negedge clk);
      hi &= tx_line;
    end
    check("midrst_line_quiet", 32'(hi), 32'd1);
    check("midrst_busy_after", 32'(tx_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
